// File: rtl/input_layer_mb.sv
// input_layer_mb
// Input stage of the network. Samples are queued in a FIFO and then copied,
// one at a time, into a broadcast register that feeds NS state consumers.
// In TRAIN mode every branch gets the sample, and each load issues a sink
// token. A token is retired when the first hidden layer offers a weight and
// a delta together. In TEST mode only branch 0 gets the sample and no token
// is issued.
//
// Ports:
//   iCLK, iRST          clock, synchronous active-high reset
//   iMode               MODE_TRAIN / MODE_TEST, sampled only when a sample loads
//   *_AM_Input          sample input handshake (valid/ready/data)
//   *_BM_State          per-branch outputs; branch k uses data slice k
//   *_AS_Weight/Delta0  joint sink handshake; the data is discarded
//   oLevel              FIFO occupancy (the broadcast register is not counted)
//
// Build option: define INPUT_LAYER_MB_BURST_EN to let a new sample load in the
// same cycle that the last pending branch is accepted (one sample per cycle).
// Without it, a load waits for an empty pending mask (one sample per two cycles).
module input_layer_mb #(
  parameter int   NC         = 7,
  parameter int   NN         = 6,
  parameter int   WV         = 5,
  parameter int   NS         = 2,
  parameter int   DEPTH      = 4,
  parameter int   NT         = 4,
  parameter logic MODE_TRAIN = 1'b1,
  parameter logic MODE_TEST  = 1'b0
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iMode,
  input  logic                     iValid_AM_Input,
  output logic                     oReady_AM_Input,
  input  logic [NC*WV-1:0]         iData_AM_Input,
  output logic [NS-1:0]            oValid_BM_State,
  input  logic [NS-1:0]            iReady_BM_State,
  output logic [NS*NC*WV-1:0]      oData_BM_State,
  input  logic                     iValid_AS_Weight,
  output logic                     oReady_AS_Weight,
  input  logic [NC*NN*WV-1:0]      iData_AS_Weight,
  input  logic                     iValid_AS_Delta0,
  output logic                     oReady_AS_Delta0,
  input  logic [NN*WV-1:0]         iData_AS_Delta0,
  output logic [$clog2(DEPTH):0]   oLevel
);

  localparam int SW = NC * WV;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(NT + 1);

  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [NS-1:0] pend, pend_next;
  logic [SW-1:0] data_q;
  logic          mode_q;
  logic [TW-1:0] tok;

  logic push, load, wvld, slot_free, mode_ok, is_train, tok_inc;
  logic unused_bits;

  // Ready comes from the registered level, so a pop never raises it in the same cycle.
  assign oReady_AM_Input = !iRST && (level != LW'(DEPTH));
  assign push            = iValid_AM_Input && oReady_AM_Input;
  assign pend_next       = pend & ~iReady_BM_State;

`ifdef INPUT_LAYER_MB_BURST_EN
  assign slot_free = (pend_next == '0);
`else
  assign slot_free = (pend == '0);
`endif

  // An unrecognised mode blocks loads, so the broadcast side holds its state.
  assign mode_ok  = (iMode == MODE_TRAIN) || (iMode == MODE_TEST);
  assign is_train = (iMode == MODE_TRAIN);
  assign load     = (level != '0) && slot_free && mode_ok &&
                    (!is_train || (tok < TW'(NT)));
  assign tok_inc  = load && is_train;
  assign wvld     = !iRST && (tok != '0) && iValid_AS_Weight && iValid_AS_Delta0;

  assign oValid_BM_State  = pend;
  assign oData_BM_State   = {NS{data_q}};
  assign oReady_AS_Weight = wvld;
  assign oReady_AS_Delta0 = wvld;
  assign oLevel           = level;

  // The sink data and the latched mode have no consumer inside this block.
  assign unused_bits = ^{iData_AS_Weight, iData_AS_Delta0, mode_q};

  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= iData_AM_Input;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      pend   <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      tok    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;

      case ({push, load})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (load) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        mode_q <= iMode;
        pend   <= is_train ? '1 : NS'(1);
      end else begin
        pend   <= pend_next;
      end

      case ({tok_inc, wvld})
        2'b10:   tok <= tok + 1'b1;
        2'b01:   tok <= tok - 1'b1;
        default: tok <= tok;
      endcase
    end
  end

endmodule
